// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_st_t;

  localparam int CMD_W = 16;
  localparam logic [CMD_W-1:0] TMO_DATA = 16'hFFFF;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// rtl/spi_arb_rr_pick.sv - combinational winner selection, round-robin or fixed priority
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] cand;
  logic          found;

  // Round-robin scans from the slot after the last winner; fixed priority scans from 0.
  always_comb begin
    win   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (PRIO_MODE != 0) cand = PW'(k);
      else                cand = PW'((int'(ptr) + 1 + k) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - grants one requester per 16-bit SPI transaction and returns its read data
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PRIO_MODE = 0,
  parameter int TMO_CYC   = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [CMD_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [CMD_W-1:0]      rdata,
  output logic                  tmo_err,
  output logic                  busy,
  output logic                  spi_wrt,
  output logic [CMD_W-1:0]      spi_cmd,
  input  logic                  spi_done,
  input  logic [CMD_W-1:0]      spi_rd
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TMO_CYC);

  arb_st_t          state, state_n;
  logic [NREQ-1:0]  gnt_n, done_n, win;
  logic [CMD_W-1:0] rdata_n, cmd_n;
  logic             tmo_n, wrt_n;
  logic [PW-1:0]    ptr, ptr_n, owner, owner_n, win_idx;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CMD_W-1:0] cmd_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_cmd
    assign cmd_arr[i] = wdata[CMD_W*i +: CMD_W];
  end

  rr_pick #(
    .NREQ      (NREQ),
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      tmo_err <= 1'b0;
      spi_wrt <= 1'b0;
      spi_cmd <= '0;
      ptr     <= PW'(NREQ-1);
      owner   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      done    <= done_n;
      rdata   <= rdata_n;
      tmo_err <= tmo_n;
      spi_wrt <= wrt_n;
      spi_cmd <= cmd_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
    end
  end

  // Every output is a register, so each pulse is set on the edge that enters its state.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    rdata_n = rdata;
    tmo_n   = 1'b0;
    wrt_n   = 1'b0;
    cmd_n   = spi_cmd;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = win;
          owner_n = win_idx;
          cmd_n   = cmd_arr[win_idx];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wrt_n   = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (spi_done) begin
          rdata_n = spi_rd;
          done_n  = gnt;
          gnt_n   = '0;
          state_n = DONE;
        end else if (cnt == CW'(TMO_CYC-1)) begin
          rdata_n = TMO_DATA;
          tmo_n   = 1'b1;
          done_n  = gnt;
          gnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        ptr_n   = owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - randomized and directed bench for spi_arb, round-robin and fixed-priority instances
module tb_spi_arb;

  localparam int NR  = 2;
  localparam int TMO = 64;

  typedef struct {
    bit          act;
    bit          fin;
    bit          tmo;
    int          owner;
    int          age;
    int          last;
    logic [15:0] cmd;
    logic [15:0] rd;
  } mdl_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [16*NR-1:0]  wdata;
  logic [1:0]        sdone;
  logic [15:0]       srd     [2];
  logic [NR-1:0]     gnt_o   [2];
  logic [NR-1:0]     done_o  [2];
  logic [15:0]       rdata_o [2];
  logic [15:0]       cmd_o   [2];
  logic              tmo_o   [2];
  logic              busy_o  [2];
  logic              wrt_o   [2];

  mdl_t        m [2];
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  int          lat_fix;
  logic [15:0] fixed_rd;
  int          dq_rr [$];
  int          dq_fp [$];

  always #5 clk = ~clk;

  spi_arb #(.NREQ(NR), .PRIO_MODE(0), .TMO_CYC(TMO)) u_rr (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_o[0]), .done(done_o[0]), .rdata(rdata_o[0]), .tmo_err(tmo_o[0]),
    .busy(busy_o[0]), .spi_wrt(wrt_o[0]), .spi_cmd(cmd_o[0]),
    .spi_done(sdone[0]), .spi_rd(srd[0])
  );

  spi_arb #(.NREQ(NR), .PRIO_MODE(1), .TMO_CYC(TMO)) u_fp (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_o[1]), .done(done_o[1]), .rdata(rdata_o[1]), .tmo_err(tmo_o[1]),
    .busy(busy_o[1]), .spi_wrt(wrt_o[1]), .spi_cmd(cmd_o[1]),
    .spi_done(sdone[1]), .spi_rd(srd[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input logic [NR-1:0] r, input int last);
    int rv = int'(r);
    for (int k = 1; k <= NR; k++) begin
      int i = (mode != 0) ? k - 1 : (last + k) % NR;
      if (((rv >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  // Transaction view: age counts edges since the grant; age 1 is the first waiting cycle.
  function automatic mdl_t step_m(input mdl_t s, input int mode, input logic r,
                                  input logic [NR-1:0] rq, input logic [16*NR-1:0] wd,
                                  input logic sd, input logic [15:0] sr);
    mdl_t n = s;
    if (r) begin
      n.act = 0; n.fin = 0; n.tmo = 0; n.owner = 0; n.age = 0;
      n.last = NR - 1; n.cmd = '0; n.rd = '0;
    end else if (s.fin) begin
      n.fin = 0; n.tmo = 0; n.act = 0; n.last = s.owner;
    end else if (!s.act) begin
      if (rq != 0) begin
        n.owner = pick(mode, rq, s.last);
        n.cmd   = 16'(wd >> (16 * n.owner));
        n.act   = 1;
        n.age   = 0;
      end
    end else if (s.age == 0) begin
      n.age = 1;
    end else if (sd) begin
      n.rd = sr; n.fin = 1;
    end else if (s.age == TMO) begin
      n.rd = 16'hFFFF; n.fin = 1; n.tmo = 1;
    end else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= step_m(m[0], 0, rst, req, wdata, sdone[0], srd[0]);
    m[1] <= step_m(m[1], 1, rst, req, wdata, sdone[1], srd[1]);
  end

  // SPI master stand-in: answers each spi_wrt after a chosen number of waiting cycles.
  initial begin
    int cd [2];
    int r;
    cd[0] = 0; cd[1] = 0; sdone = '0; srd[0] = '0; srd[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        sdone[d] = 1'b0;
        srd[d]   = 16'($urandom);
        if (cd[d] > 0) begin
          cd[d]--;
          if (cd[d] == 0) begin
            sdone[d] = 1'b1;
            srd[d]   = (lat_fix > 0) ? fixed_rd : 16'($urandom);
          end
        end
        if (wrt_o[d]) begin
          if (lat_fix >= 0) cd[d] = lat_fix;
          else begin
            r = $urandom_range(0, 9);
            case (r)
              0:       cd[d] = 0;
              1:       cd[d] = TMO - 1;
              2:       cd[d] = TMO;
              3:       cd[d] = TMO + 1;
              default: cd[d] = $urandom_range(1, 20);
            endcase
          end
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] eg, ed;
    forever begin
      @(negedge clk);
      if (done_o[0] != 0) dq_rr.push_back(done_o[0] == 2'b10 ? 1 : 0);
      if (done_o[1] != 0) dq_fp.push_back(done_o[1] == 2'b10 ? 1 : 0);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          eg = (m[d].act && !m[d].fin) ? NR'(1 << m[d].owner) : '0;
          ed = m[d].fin ? NR'(1 << m[d].owner) : '0;
          chk($sformatf("u%0d gnt", d), 32'(gnt_o[d]), 32'(eg));
          chk($sformatf("u%0d done", d), 32'(done_o[d]), 32'(ed));
          chk($sformatf("u%0d tmo_err", d), 32'(tmo_o[d]), 32'(m[d].fin && m[d].tmo));
          chk($sformatf("u%0d busy", d), 32'(busy_o[d]), 32'(m[d].act));
          chk($sformatf("u%0d spi_wrt", d), 32'(wrt_o[d]), 32'(m[d].act && !m[d].fin && m[d].age == 1));
          chk($sformatf("u%0d rdata", d), 32'(rdata_o[d]), 32'(m[d].rd));
          if (m[d].act) chk($sformatf("u%0d spi_cmd", d), 32'(cmd_o[d]), 32'(m[d].cmd));
        end
      end
    end
  end

  task automatic wait_done(input int d, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o[d] == 0 && n < bound);
  endtask

  task automatic wait_wrt(input int d, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrt_o[d] && n < bound);
  endtask

  initial begin
    int n, pulses;
    rst = 1'b1; req = '0; wdata = '0; lat_fix = 5; fixed_rd = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset gnt", 32'(gnt_o[0]), 32'h0);
    chk("reset done", 32'(done_o[0]), 32'h0);
    chk("reset rdata", 32'(rdata_o[0]), 32'h0);
    chk("reset busy", 32'(busy_o[0]), 32'h0);
    chk("reset spi_wrt", 32'(wrt_o[0]), 32'h0);
    chk("reset spi_cmd", 32'(cmd_o[0]), 32'h0);
    rst = 1'b0;

    lat_fix = 40; fixed_rd = 16'h0069; wdata = 32'h1234_8F00; req = 2'b01;
    @(negedge clk);
    chk("single gnt", 32'(gnt_o[0]), 32'h1);
    chk("single wrt early", 32'(wrt_o[0]), 32'h0);
    req = 2'b00;
    @(negedge clk);
    chk("single spi_wrt", 32'(wrt_o[0]), 32'h1);
    chk("single spi_cmd", 32'(cmd_o[0]), 32'h8F00);
    wait_done(0, 200, n);
    chk("single done latency", 32'(n), 32'd41);
    chk("single done", 32'(done_o[0]), 32'h1);
    chk("single rdata", 32'(rdata_o[0]), 32'h0069);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; lat_fix = 5; wdata = $urandom;
    dq_rr.delete(); dq_fp.delete();
    req = 2'b11;
    n = 0;
    while (dq_rr.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant %0d", i), 32'(dq_rr.size() > i ? dq_rr[i] : -1), 32'(i % 2));
      chk($sformatf("fp grant %0d", i), 32'(dq_fp.size() > i ? dq_fp[i] : -1), 32'h0);
    end
    repeat (20) @(negedge clk);

    lat_fix = 0; req = 2'b01;
    wait_wrt(0, 10, n);
    req = 2'b00;
    wait_done(0, TMO + 20, n);
    chk("timeout latency", 32'(n), 32'(TMO));
    chk("timeout tmo_err", 32'(tmo_o[0]), 32'h1);
    chk("timeout rdata", 32'(rdata_o[0]), 32'hFFFF);
    @(negedge clk);
    chk("timeout idle", 32'(busy_o[0]), 32'h0);

    lat_fix = TMO - 1; fixed_rd = 16'hA5C3; req = 2'b01;
    wait_wrt(0, 10, n);
    req = 2'b00;
    wait_done(0, TMO + 20, n);
    chk("tie latency", 32'(n), 32'(TMO));
    chk("tie tmo_err", 32'(tmo_o[0]), 32'h0);
    chk("tie rdata", 32'(rdata_o[0]), 32'hA5C3);
    repeat (3) @(negedge clk);

    lat_fix = 20; req = 2'b01;
    wait_wrt(0, 10, n);
    req = 2'b00;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wait-reset gnt", 32'(gnt_o[0]), 32'h0);
    chk("wait-reset busy", 32'(busy_o[0]), 32'h0);
    chk("wait-reset spi_wrt", 32'(wrt_o[0]), 32'h0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o[0] != 0) pulses++;
    end
    chk("late spi_done ignored", 32'(pulses), 32'h0);
    wdata = 32'hBEEF_0000; req = 2'b10;
    @(negedge clk);
    chk("post-reset gnt", 32'(gnt_o[0]), 32'h2);
    req = 2'b00;
    @(negedge clk);
    chk("post-reset spi_cmd", 32'(cmd_o[0]), 32'hBEEF);
    wait_done(0, 100, n);
    chk("post-reset done", 32'(done_o[0]), 32'h2);

    lat_fix = -1;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom);
      wdata = $urandom;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0; req = '0;
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
